// File: rtl/btn_cmd_pkg.sv
// Shared definitions for the button command decoder: hold-FSM encoding and
// the production hold length (5 s at 50 MHz).
package btn_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRED = 2'd2
  } hold_state_e;

  localparam int unsigned HOLD_CYCLES_DEFAULT = 250_000_000;

endpackage

// File: rtl/hold_detector.sv
// Long-press detector: emits one registered fire pulse once the synchronized
// level has been high for HOLD_CYCLES consecutive cycles; re-arms on release.
module hold_detector
  import btn_cmd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic fire
);

  localparam int unsigned     CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]   HOLD_CNT  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);

  hold_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          fire_q;

  // Counter saturates at HOLD_CYCLES on entry to FIRED, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fire_q  <= 1'b0;
    end else begin
      fire_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (level) begin
            if (HOLD_CYCLES <= 1) begin
              state_q <= FIRED;
              cnt_q   <= HOLD_CNT;
              fire_q  <= 1'b1;
            end else begin
              state_q <= COUNT;
              cnt_q   <= CW'(1);
            end
          end
        end
        COUNT: begin
          if (!level) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q <= FIRED;
            cnt_q   <= HOLD_CNT;
            fire_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIRED: begin
          if (!level) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign fire = fire_q;

endmodule

// File: rtl/btn_cmd_decoder.sv
// Four-button front end: synchronizes the buttons, turns salud/hambre presses
// into single-cycle commands and reset/test long presses into reset/test-mode.
module btn_cmd_decoder
  import btn_cmd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_salud,
  input  logic btn_hambre,
  input  logic btn_reset,
  input  logic btn_test,
  output logic cmd_heal,
  output logic cmd_feed,
  output logic cmd_reset,
  output logic test_step,
  output logic test_mode
);

  // Bit order: {test, reset, hambre, salud}
  logic [3:0] sync1_q, sync2_q;
  logic [1:0] prev_q;
  logic       reset_fire, test_fire;
  logic       heal_edge, feed_edge;
  logic       cmd_heal_q, cmd_feed_q, cmd_reset_q, test_step_q, test_mode_q;
  logic       cmd_heal_d, cmd_feed_d, cmd_reset_d, test_step_d, test_mode_d;

  hold_detector #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_reset (
    .clk   (clk),
    .rst_n (rst_n),
    .level (sync2_q[2]),
    .fire  (reset_fire)
  );

  hold_detector #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_test (
    .clk   (clk),
    .rst_n (rst_n),
    .level (sync2_q[3]),
    .fire  (test_fire)
  );

  // Salud routing uses test_mode_q, i.e. the value before any same-cycle toggle.
  always_comb begin
    heal_edge   = sync2_q[0] & ~prev_q[0];
    feed_edge   = sync2_q[1] & ~prev_q[1];
    cmd_heal_d  = heal_edge & ~test_mode_q;
    test_step_d = heal_edge & test_mode_q;
    cmd_feed_d  = feed_edge;
    cmd_reset_d = reset_fire;
    test_mode_d = test_mode_q;
    if (reset_fire) begin
      test_mode_d = 1'b0;
    end else if (test_fire) begin
      test_mode_d = ~test_mode_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      cmd_heal_q  <= 1'b0;
      cmd_feed_q  <= 1'b0;
      cmd_reset_q <= 1'b0;
      test_step_q <= 1'b0;
      test_mode_q <= 1'b0;
    end else begin
      sync1_q     <= {btn_test, btn_reset, btn_hambre, btn_salud};
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q[1:0];
      cmd_heal_q  <= cmd_heal_d;
      cmd_feed_q  <= cmd_feed_d;
      cmd_reset_q <= cmd_reset_d;
      test_step_q <= test_step_d;
      test_mode_q <= test_mode_d;
    end
  end

  assign cmd_heal  = cmd_heal_q;
  assign cmd_feed  = cmd_feed_q;
  assign cmd_reset = cmd_reset_q;
  assign test_step = test_step_q;
  assign test_mode = test_mode_q;

endmodule
